// File: rtl/rename_commit_buffer.sv
// In-order commit tracker for rename allocations; feeds the free list with released pregs.
// Optional RCB_BYPASS_EN: a completion that hits the head lets the head commit in the same cycle.
module rename_commit_buffer #(
  parameter int DEPTH  = 16,
  parameter int PREG_W = 6,
  parameter int AREG_W = 5,
  localparam int TAG_W = $clog2(DEPTH),
  localparam int NAREG = 1 << AREG_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              alloc_valid,
  input  logic [AREG_W-1:0] alloc_areg,
  input  logic [PREG_W-1:0] alloc_preg,
  input  logic [PREG_W-1:0] alloc_old_preg,
  output logic [TAG_W-1:0]  alloc_tag,
  output logic              full,
  input  logic              done_valid,
  input  logic [TAG_W-1:0]  done_tag,
  output logic              commit_valid,
  output logic [AREG_W-1:0] commit_areg,
  output logic [PREG_W-1:0] commit_preg,
  output logic              free_enque,
  output logic [PREG_W-1:0] free_data,
  output logic [PREG_W-1:0] r_mapping [NAREG-1:0]
);

  localparam logic [TAG_W-1:0] TAG_ONE    = 1;
  localparam logic [TAG_W:0]   COUNT_ONE  = 1;
  localparam logic [TAG_W:0]   COUNT_FULL = DEPTH[TAG_W:0];

  logic [DEPTH-1:0]  valid_reg;
  logic [DEPTH-1:0]  done_reg;
  logic [TAG_W-1:0]  head_reg;
  logic [TAG_W-1:0]  tail_reg;
  logic [TAG_W:0]    count_reg;

  logic [AREG_W-1:0] areg_mem [DEPTH];
  logic [PREG_W-1:0] preg_mem [DEPTH];
  logic [PREG_W-1:0] old_mem  [DEPTH];

  logic alloc_fire;
  logic done_hit;
  logic head_done;
  logic commit_fire;

  assign full      = (count_reg == COUNT_FULL);
  assign alloc_tag = tail_reg;

  assign alloc_fire = alloc_valid & ~stall & ~full & ~flush;
  assign done_hit   = done_valid & valid_reg[done_tag] & ~flush;

`ifdef RCB_BYPASS_EN
  assign head_done = done_reg[head_reg] | (done_valid & (done_tag == head_reg));
`else
  assign head_done = done_reg[head_reg];
`endif

  assign commit_fire = valid_reg[head_reg] & head_done & ~stall & ~flush;

  // Record payload needs no reset: it is only read behind a set valid bit.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      areg_mem[tail_reg] <= alloc_areg;
      preg_mem[tail_reg] <= alloc_preg;
      old_mem[tail_reg]  <= alloc_old_preg;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_reg <= '0;
      done_reg  <= '0;
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (flush) begin
      valid_reg <= '0;
      done_reg  <= '0;
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      // Alloc and commit never target the same slot: that would need a full ring.
      for (int i = 0; i < DEPTH; i++) begin
        if (done_hit && (done_tag == TAG_W'(i)))
          done_reg[i] <= 1'b1;
        if (alloc_fire && (tail_reg == TAG_W'(i))) begin
          valid_reg[i] <= 1'b1;
          done_reg[i]  <= 1'b0;
        end else if (commit_fire && (head_reg == TAG_W'(i))) begin
          valid_reg[i] <= 1'b0;
        end
      end
      if (alloc_fire)
        tail_reg <= tail_reg + TAG_ONE;
      if (commit_fire)
        head_reg <= head_reg + TAG_ONE;
      case ({alloc_fire, commit_fire})
        2'b10:   count_reg <= count_reg + COUNT_ONE;
        2'b01:   count_reg <= count_reg - COUNT_ONE;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Committed map survives flush; it is what the free list rebuilds from.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NAREG; i++)
        r_mapping[i] <= PREG_W'(i);
    end else if (commit_fire) begin
      r_mapping[areg_mem[head_reg]] <= preg_mem[head_reg];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      commit_valid <= 1'b0;
      free_enque   <= 1'b0;
      commit_areg  <= '0;
      commit_preg  <= '0;
      free_data    <= '0;
    end else begin
      commit_valid <= commit_fire;
      free_enque   <= commit_fire;
      commit_areg  <= commit_fire ? areg_mem[head_reg] : '0;
      commit_preg  <= commit_fire ? preg_mem[head_reg] : '0;
      free_data    <= commit_fire ? old_mem[head_reg]  : '0;
    end
  end

endmodule

// File: tb/tb_rename_commit_buffer.sv
// Bench for rename_commit_buffer: directed scenarios then random traffic against a queue model.
// Define RCB_BYPASS_EN to match a bypass build of the design.
module tb_rename_commit_buffer;

  localparam int DEPTH  = 16;
  localparam int PREG_W = 6;
  localparam int AREG_W = 5;
  localparam int TAG_W  = 4;
`ifdef RCB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic              stall;
  logic              flush;
  logic              alloc_valid;
  logic [AREG_W-1:0] alloc_areg;
  logic [PREG_W-1:0] alloc_preg;
  logic [PREG_W-1:0] alloc_old_preg;
  logic [TAG_W-1:0]  alloc_tag;
  logic              full;
  logic              done_valid;
  logic [TAG_W-1:0]  done_tag;
  logic              commit_valid;
  logic [AREG_W-1:0] commit_areg;
  logic [PREG_W-1:0] commit_preg;
  logic              free_enque;
  logic [PREG_W-1:0] free_data;
  logic [PREG_W-1:0] r_mapping [31:0];

  rename_commit_buffer #(.DEPTH(DEPTH), .PREG_W(PREG_W), .AREG_W(AREG_W)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_areg(alloc_areg), .alloc_preg(alloc_preg),
    .alloc_old_preg(alloc_old_preg), .alloc_tag(alloc_tag), .full(full),
    .done_valid(done_valid), .done_tag(done_tag),
    .commit_valid(commit_valid), .commit_areg(commit_areg), .commit_preg(commit_preg),
    .free_enque(free_enque), .free_data(free_data), .r_mapping(r_mapping)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: outstanding records in program order, plus the committed map.
  typedef struct {
    logic [AREG_W-1:0] areg;
    logic [PREG_W-1:0] preg;
    logic [PREG_W-1:0] old;
    int                tag;
    bit                done;
  } rec_t;

  rec_t              q[$];
  int                tail_m;
  logic [PREG_W-1:0] map_m [32];
  bit                exp_cv;
  logic [AREG_W-1:0] exp_areg;
  logic [PREG_W-1:0] exp_preg;
  logic [PREG_W-1:0] exp_fd;
  logic [PREG_W-1:0] fd_log[$];
  int                checks = 0;
  int                errors = 0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit was_full;
    bit do_commit;
    rec_t r;
    exp_cv = 1'b0; exp_areg = '0; exp_preg = '0; exp_fd = '0;
    if (flush) begin
      q.delete();
      tail_m = 0;
      return;
    end
    was_full  = (q.size() == DEPTH);
    do_commit = (q.size() > 0) && !stall &&
                (q[0].done || (BYP && done_valid && (q[0].tag == int'(done_tag))));
    if (done_valid)
      foreach (q[i]) if (q[i].tag == int'(done_tag)) q[i].done = 1'b1;
    if (do_commit) begin
      exp_cv   = 1'b1;
      exp_areg = q[0].areg;
      exp_preg = q[0].preg;
      exp_fd   = q[0].old;
      map_m[q[0].areg] = q[0].preg;
      void'(q.pop_front());
    end
    if (alloc_valid && !stall && !was_full) begin
      r.areg = alloc_areg; r.preg = alloc_preg; r.old = alloc_old_preg;
      r.tag = tail_m; r.done = 1'b0;
      q.push_back(r);
      tail_m = (tail_m + 1) % DEPTH;
    end
  endtask

  // Inputs are already applied; check combinational outputs, advance one edge, check registered ones.
  task automatic step();
    #1;
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("alloc_tag", 32'(alloc_tag), 32'(tail_m));
    model_edge();
    @(posedge clk);
    #1;
    if (free_enque === 1'b1) fd_log.push_back(free_data);
    chk("commit_valid", 32'(commit_valid), 32'(exp_cv));
    chk("free_enque", 32'(free_enque), 32'(exp_cv));
    chk("commit_areg", 32'(commit_areg), 32'(exp_areg));
    chk("commit_preg", 32'(commit_preg), 32'(exp_preg));
    chk("free_data", 32'(free_data), 32'(exp_fd));
    for (int i = 0; i < 32; i++)
      chk($sformatf("r_mapping[%0d]", i), 32'(r_mapping[i]), 32'(map_m[i]));
    $display("cyc: av=%0b dv=%0b dtag=%0d st=%0b fl=%0b -> cv=%0b fd=%0d q=%0d",
             alloc_valid, done_valid, done_tag, stall, flush, commit_valid, free_data, q.size());
  endtask

  task automatic drive(input bit av, input int ar, input int pr, input int od,
                       input bit dv, input int dt, input bit st, input bit fl);
    alloc_valid    = av;
    alloc_areg     = AREG_W'(ar);
    alloc_preg     = PREG_W'(pr);
    alloc_old_preg = PREG_W'(od);
    done_valid     = dv;
    done_tag       = TAG_W'(dt);
    stall          = st;
    flush          = fl;
    step();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; flush = 1'b0; alloc_valid = 1'b0;
    alloc_areg = '0; alloc_preg = '0; alloc_old_preg = '0;
    done_valid = 1'b0; done_tag = '0;
    for (int i = 0; i < 32; i++) map_m[i] = PREG_W'(i);
    tail_m = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_r_mapping5", 32'(r_mapping[5]), 32'd5);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_free_enque", 32'(free_enque), 32'd0);
    chk("rst_alloc_tag", 32'(alloc_tag), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Three allocs, completions out of order, commits in order.
    fd_log.delete();
    drive(1, 3, 32, 3, 0, 0, 0, 0);
    drive(1, 4, 33, 4, 0, 0, 0, 0);
    drive(1, 3, 34, 32, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 2, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 1, 0, 0);
    idle(4);
    chk("t2_commits", fd_log.size(), 32'd3);
    if (fd_log.size() == 3) begin
      chk("t2_fd0", 32'(fd_log[0]), 32'd3);
      chk("t2_fd1", 32'(fd_log[1]), 32'd4);
      chk("t2_fd2", 32'(fd_log[2]), 32'd32);
    end
    chk("t2_map3", 32'(r_mapping[3]), 32'd34);
    chk("t2_map4", 32'(r_mapping[4]), 32'd33);

    // Fill the ring, then an extra alloc is dropped.
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < DEPTH; k++) drive(1, k, 40 + k, k, 0, 0, 0, 0);
    #1;
    chk("t3_full", 32'(full), 32'd1);
    chk("t3_tag_full", 32'(alloc_tag), 32'd0);
    drive(1, 20, 63, 20, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    idle(2);
    #1;
    chk("t3_not_full", 32'(full), 32'd0);
    chk("t3_reuse_tag", 32'(alloc_tag), 32'd0);
    drive(1, 21, 62, 21, 0, 0, 0, 0);

    // Partial commits then a flush that also squashes a completion.
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 5; k++) drive(1, 7 + k, 50 + k, 7 + k, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 1, 0, 0);
    idle(2);
    drive(0, 0, 0, 0, 1, 2, 0, 1);
    chk("t4_flush_enque", 32'(free_enque), 32'd0);
    chk("t4_flush_tag", 32'(alloc_tag), 32'd0);
    chk("t4_map7", 32'(r_mapping[7]), 32'd50);
    chk("t4_map8", 32'(r_mapping[8]), 32'd51);
    idle(2);

    // Stall holds a ready head.
    drive(1, 9, 55, 9, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    chk("t5_stalled", 32'(commit_valid), 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t5_release", 32'(commit_valid), 32'd1);
    idle(1);

    // Completion-to-commit latency.
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    drive(1, 10, 60, 10, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    chk("t6_first_edge", 32'(free_enque), 32'(BYP));
    idle(1);
    chk("t6_second_edge", 32'(free_enque), 32'(!BYP));
    idle(1);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      int dt;
      if ((q.size() > 0) && ($urandom_range(3) != 0))
        dt = q[$urandom_range(q.size() - 1)].tag;
      else
        dt = int'($urandom_range(DEPTH - 1));
      drive($urandom_range(9) < 6, int'($urandom_range(31)), int'($urandom_range(63)),
            int'($urandom_range(63)), $urandom_range(1) == 1, dt,
            $urandom_range(4) == 0, $urandom_range(31) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
